// File: rtl/gppcu_lmem_dma_pkg.sv
// rtl/gppcu_lmem_dma_pkg.sv - shared GPPCU LMEM DMA parameters, command constants and FSM encoding
package gppcu_lmem_dma_pkg;

    localparam int LMEM_ABW = 11;
    localparam int LMEM_DBW = 32;

    localparam logic CMD_DIR_WRITE = 1'b0;
    localparam logic CMD_DIR_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } dmaState_t;

endpackage

// File: rtl/gppcu_lmem_dma_rdbuf.sv
// rtl/gppcu_lmem_dma_rdbuf.sv - 2-entry read-data FIFO with occupancy count
module gppcu_lmem_dma_rdbuf #(
    parameter int DBW = 32
) (
    input  logic           iACLK,
    input  logic           iARST,
    input  logic           iPUSH,
    input  logic [DBW-1:0] iDATA,
    input  logic           iPOP,
    output logic [DBW-1:0] oDATA,
    output logic           oVALID,
    output logic [1:0]     oCOUNT
);

    logic [DBW-1:0] mem [2];
    logic           wrPtr;
    logic           rdPtr;
    logic [1:0]     count;
    logic           popEn;

    assign popEn  = iPOP && (count != 2'd0);
    assign oDATA  = mem[rdPtr];
    assign oVALID = (count != 2'd0);
    assign oCOUNT = count;

    always_ff @(posedge iACLK) begin
        if (iARST) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (iPUSH) begin
                mem[wrPtr] <= iDATA;
                wrPtr      <= ~wrPtr;
            end
            if (popEn) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + 2'(iPUSH) - 2'(popEn);
        end
    end

endmodule

// File: rtl/gppcu_lmem_dma.sv
// rtl/gppcu_lmem_dma.sv - host stream <-> per-thread LMEM block mover with broadcast write
module gppcu_lmem_dma
    import gppcu_lmem_dma_pkg::*;
#(
    parameter int NTHREAD = 8,
    parameter int ABW     = LMEM_ABW,
    parameter int DBW     = LMEM_DBW,
    parameter int TBW     = $clog2(NTHREAD)
) (
    input  logic                   iACLK,
    input  logic                   iARST,
    input  logic                   iCMD_VALID,
    output logic                   oCMD_READY,
    input  logic                   iCMD_DIR,
    input  logic                   iCMD_BCAST,
    input  logic [TBW-1:0]         iCMD_THREAD,
    input  logic [ABW-1:0]         iCMD_ADDR,
    input  logic [ABW:0]           iCMD_LEN,
    input  logic                   iWR_VALID,
    output logic                   oWR_READY,
    input  logic [DBW-1:0]         iWR_DATA,
    output logic                   oRD_VALID,
    input  logic                   iRD_READY,
    output logic [DBW-1:0]         oRD_DATA,
    output logic [NTHREAD-1:0]     oLMEMSEL,
    output logic                   oLMEMWREN,
    output logic [ABW-1:0]         oLMEMADDR,
    output logic [DBW-1:0]         oLMEMWDATA,
    input  logic [NTHREAD*DBW-1:0] iLMEMRDATA,
    output logic                   oBUSY,
    output logic                   oDONE,
    output logic                   oERR
);

    dmaState_t          state, stateNext;
    logic [ABW-1:0]     addrQ;
    logic [ABW:0]       remainQ;
    logic [TBW-1:0]     threadQ;
    logic               bcastQ;
    logic               doneQ, errQ;
    logic [NTHREAD-1:0] lmemSelQ;
    logic               lmemWrenQ;
    logic [ABW-1:0]     lmemAddrQ;
    logic [DBW-1:0]     lmemWdataQ;
    logic               rdPend1, rdPend2;

    logic               cmdFire, wrBeat, rdIssue, doneNext, errNext, pop;
    logic [NTHREAD-1:0] selWord;
    logic [DBW-1:0]     rdWord;
    logic [1:0]         bufCount;
    logic [2:0]         rdOccupancy;

    assign oCMD_READY = (state == ST_IDLE) && !doneQ;
    assign oWR_READY  = (state == ST_WRITE);
    assign oBUSY      = (state != ST_IDLE);
    assign oDONE      = doneQ;
    assign oERR       = errQ;
    assign oLMEMSEL   = lmemSelQ;
    assign oLMEMWREN  = lmemWrenQ;
    assign oLMEMADDR  = lmemAddrQ;
    assign oLMEMWDATA = lmemWdataQ;

    assign cmdFire = iCMD_VALID && oCMD_READY;
    assign pop     = oRD_VALID && iRD_READY;
    assign selWord = bcastQ ? '1 : (NTHREAD'(1) << threadQ);

    // Everything that will land in the buffer: stored words, the word on the
    // bus this cycle and the strobe just issued.
    assign rdOccupancy = 3'(bufCount) + 3'(rdPend1) + 3'(rdPend2);

    always_comb begin
        rdWord = '0;
        for (int k = 0; k < NTHREAD; k++) begin
            if (threadQ == TBW'(k)) begin
                rdWord = iLMEMRDATA[k*DBW +: DBW];
            end
        end
    end

    always_comb begin
        stateNext = state;
        doneNext  = 1'b0;
        errNext   = 1'b0;
        wrBeat    = 1'b0;
        rdIssue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmdFire) begin
                    if (iCMD_LEN == '0) begin
                        doneNext = 1'b1;
                    end else if (!(iCMD_BCAST && iCMD_DIR == CMD_DIR_WRITE) &&
                                 32'(iCMD_THREAD) >= NTHREAD) begin
                        doneNext = 1'b1;
                        errNext  = 1'b1;
                    end else begin
                        stateNext = (iCMD_DIR == CMD_DIR_READ) ? ST_READ : ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (iWR_VALID) begin
                    wrBeat = 1'b1;
                    if (remainQ == (ABW+1)'(1)) begin
                        stateNext = ST_IDLE;
                        doneNext  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // A pop this cycle frees a slot before the new word can arrive.
                if (remainQ != '0 && rdOccupancy <= 3'(pop) + 3'd1) begin
                    rdIssue = 1'b1;
                    if (remainQ == (ABW+1)'(1)) begin
                        stateNext = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!rdPend1 && !rdPend2 && bufCount == 2'd0) begin
                    stateNext = ST_IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge iACLK) begin
        if (iARST) begin
            state      <= ST_IDLE;
            addrQ      <= '0;
            remainQ    <= '0;
            threadQ    <= '0;
            bcastQ     <= 1'b0;
            doneQ      <= 1'b0;
            errQ       <= 1'b0;
            lmemSelQ   <= '0;
            lmemWrenQ  <= 1'b0;
            lmemAddrQ  <= '0;
            lmemWdataQ <= '0;
            rdPend1    <= 1'b0;
            rdPend2    <= 1'b0;
        end else begin
            state   <= stateNext;
            doneQ   <= doneNext;
            errQ    <= errNext;
            rdPend1 <= rdIssue;
            rdPend2 <= rdPend1;
            if (cmdFire) begin
                addrQ   <= iCMD_ADDR;
                remainQ <= iCMD_LEN;
                threadQ <= iCMD_THREAD;
                bcastQ  <= iCMD_BCAST && (iCMD_DIR == CMD_DIR_WRITE);
            end else if (wrBeat || rdIssue) begin
                addrQ   <= addrQ + 1'b1;
                remainQ <= remainQ - 1'b1;
            end
            lmemSelQ  <= '0;
            lmemWrenQ <= 1'b0;
            if (wrBeat) begin
                lmemSelQ   <= selWord;
                lmemWrenQ  <= 1'b1;
                lmemAddrQ  <= addrQ;
                lmemWdataQ <= iWR_DATA;
            end else if (rdIssue) begin
                lmemSelQ  <= selWord;
                lmemAddrQ <= addrQ;
            end
        end
    end

    gppcu_lmem_dma_rdbuf #(.DBW(DBW)) uRdBuf (
        .iACLK  (iACLK),
        .iARST  (iARST),
        .iPUSH  (rdPend2),
        .iDATA  (rdWord),
        .iPOP   (pop),
        .oDATA  (oRD_DATA),
        .oVALID (oRD_VALID),
        .oCOUNT (bufCount)
    );

endmodule

// File: tb/tb_gppcu_lmem_dma.sv
// tb/tb_gppcu_lmem_dma.sv - directed self-checking bench for gppcu_lmem_dma
module tb_gppcu_lmem_dma;

    localparam int NT = 8;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int TW = 4;

    typedef struct packed {
        logic [NT-1:0] sel;
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } strobe_t;

    logic           iACLK, iARST;
    logic           iCMD_VALID, oCMD_READY, iCMD_DIR, iCMD_BCAST;
    logic [TW-1:0]  iCMD_THREAD;
    logic [AW-1:0]  iCMD_ADDR;
    logic [AW:0]    iCMD_LEN;
    logic           iWR_VALID, oWR_READY;
    logic [DW-1:0]  iWR_DATA;
    logic           oRD_VALID, iRD_READY;
    logic [DW-1:0]  oRD_DATA;
    logic [NT-1:0]  oLMEMSEL;
    logic           oLMEMWREN;
    logic [AW-1:0]  oLMEMADDR;
    logic [DW-1:0]  oLMEMWDATA;
    logic [NT*DW-1:0] iLMEMRDATA;
    logic           oBUSY, oDONE, oERR;

    int nTests = 0;
    int nFail  = 0;

    gppcu_lmem_dma #(.NTHREAD(NT), .ABW(AW), .DBW(DW), .TBW(TW)) dut (
        .iACLK(iACLK), .iARST(iARST),
        .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY), .iCMD_DIR(iCMD_DIR),
        .iCMD_BCAST(iCMD_BCAST), .iCMD_THREAD(iCMD_THREAD), .iCMD_ADDR(iCMD_ADDR),
        .iCMD_LEN(iCMD_LEN),
        .iWR_VALID(iWR_VALID), .oWR_READY(oWR_READY), .iWR_DATA(iWR_DATA),
        .oRD_VALID(oRD_VALID), .iRD_READY(iRD_READY), .oRD_DATA(oRD_DATA),
        .oLMEMSEL(oLMEMSEL), .oLMEMWREN(oLMEMWREN), .oLMEMADDR(oLMEMADDR),
        .oLMEMWDATA(oLMEMWDATA), .iLMEMRDATA(iLMEMRDATA),
        .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR)
    );

    initial begin
        iACLK = 1'b0;
        forever #5 iACLK = ~iACLK;
    end

    // Thread local memories: synchronous write, registered read-first output.
    logic [DW-1:0] lmem [NT][2**AW];
    always @(posedge iACLK) begin
        for (int k = 0; k < NT; k++) begin
            if (oLMEMSEL[k] && oLMEMWREN) lmem[k][oLMEMADDR] <= oLMEMWDATA;
            iLMEMRDATA[k*DW +: DW] <= lmem[k][oLMEMADDR];
        end
    end

    strobe_t       strobeQ[$];
    logic [DW-1:0] popQ[$];
    int cyc = 0, doneCount = 0, errCount = 0, wrBeats = 0;
    int outstanding = 0, maxOutstanding = 0, lastPopCyc = 0, doneCyc = 0;

    always @(posedge iACLK) cyc++;

    always @(negedge iACLK) begin
        if (oLMEMSEL != '0) begin
            strobeQ.push_back({oLMEMSEL, oLMEMWREN, oLMEMADDR, oLMEMWDATA});
            if (!oLMEMWREN) outstanding++;
        end
        if (outstanding > maxOutstanding) maxOutstanding = outstanding;
        if (oRD_VALID && iRD_READY) begin
            popQ.push_back(oRD_DATA);
            outstanding--;
            lastPopCyc = cyc;
        end
        if (oDONE) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (oERR) errCount++;
        if (oWR_READY && iWR_VALID) wrBeats++;
    end

    task automatic clear_mon();
        strobeQ.delete();
        popQ.delete();
        doneCount = 0; errCount = 0; wrBeats = 0;
        outstanding = 0; maxOutstanding = 0; lastPopCyc = 0; doneCyc = 0;
    endtask

    task automatic send_cmd(input logic dir, input logic bcast, input logic [TW-1:0] thr,
                            input logic [AW-1:0] addr, input logic [AW:0] len, output bit ok);
        int t = 0;
        while (!oCMD_READY && t < 50) begin
            @(posedge iACLK); #1;
            t++;
        end
        ok = oCMD_READY;
        if (ok) begin
            iCMD_VALID = 1'b1; iCMD_DIR = dir; iCMD_BCAST = bcast;
            iCMD_THREAD = thr; iCMD_ADDR = addr; iCMD_LEN = len;
            @(posedge iACLK); #1;
            iCMD_VALID = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        for (int t = 0; t < budget && doneCount == 0; t++) begin
            @(posedge iACLK); #1;
        end
        ok = (doneCount > 0);
        @(posedge iACLK); #1;
    endtask

    task automatic write_burst(input logic [TW-1:0] thr, input logic bcast, input logic [AW-1:0] addr,
                               input int n, input logic [DW-1:0] base, output bit cmdOk, output bit doneOk);
        int  k = 0;
        bit  fire;
        iWR_VALID = 1'b1;
        iWR_DATA  = base;
        send_cmd(1'b0, bcast, thr, addr, (AW+1)'(n), cmdOk);
        for (int c = 0; c < 40 && k < n; c++) begin
            fire = oWR_READY && iWR_VALID;
            @(posedge iACLK); #1;
            if (fire) begin
                k++;
                iWR_DATA = base + DW'(k);
            end
        end
        iWR_VALID = 1'b0;
        wait_done(20, doneOk);
    endtask

    task automatic read_burst(input logic [TW-1:0] thr, input logic [AW-1:0] addr, input int n,
                              input bit toggle, output bit cmdOk, output bit doneOk);
        send_cmd(1'b1, 1'b0, thr, addr, (AW+1)'(n), cmdOk);
        for (int c = 0; c < 100 && doneCount == 0; c++) begin
            iRD_READY = toggle ? (c % 3 == 0) : 1'b1;
            @(posedge iACLK); #1;
        end
        iRD_READY = 1'b0;
        doneOk = (doneCount > 0);
        @(posedge iACLK); #1;
    endtask

    task automatic test_reset();
        iARST = 1'b1;
        repeat (2) @(posedge iACLK);
        #1;
        iARST = 1'b0;
        nTests++;
        if ({oCMD_READY, oWR_READY, oRD_VALID, oLMEMWREN, oBUSY, oDONE, oERR} !== 7'b1000000) begin
            nFail++;
            $display("FAIL reset_flags: got %b expected 1000000", {oCMD_READY, oWR_READY, oRD_VALID, oLMEMWREN, oBUSY, oDONE, oERR});
        end
        nTests++;
        if ({oLMEMSEL, oLMEMADDR, oLMEMWDATA, oRD_DATA} !== '0) begin
            nFail++;
            $display("FAIL reset_data: sel=%h addr=%0d wdata=%h rdata=%h expected all 0", oLMEMSEL, oLMEMADDR, oLMEMWDATA, oRD_DATA);
        end
    endtask

    task automatic test_write();
        bit cOk, dOk;
        strobe_t exp;
        clear_mon();
        write_burst(4'd3, 1'b0, 11'd10, 4, 32'hA0, cOk, dOk);
        nTests++;
        if (!(cOk && dOk)) begin
            nFail++;
            $display("FAIL write_complete: cmd=%0d done=%0d expected 1 1", cOk, dOk);
        end
        nTests++;
        if (strobeQ.size() != 4) begin
            nFail++;
            $display("FAIL write_strobe_count: got %0d expected 4", strobeQ.size());
        end
        for (int i = 0; i < 4 && i < strobeQ.size(); i++) begin
            exp = {8'h08, 1'b1, 11'(10 + i), 32'(32'hA0 + i)};
            nTests++;
            if (strobeQ[i] !== exp) begin
                nFail++;
                $display("FAIL write_beat%0d: got %h expected %h", i, strobeQ[i], exp);
            end
        end
        nTests++;
        if (doneCount != 1 || errCount != 0 || oBUSY !== 1'b0) begin
            nFail++;
            $display("FAIL write_status: done=%0d err=%0d busy=%b expected 1 0 0", doneCount, errCount, oBUSY);
        end
    endtask

    task automatic test_bcast();
        bit cOk, dOk;
        logic [DW-1:0] got0[$];
        clear_mon();
        write_burst(4'd0, 1'b1, 11'd0, 2, 32'h5A00, cOk, dOk);
        nTests++;
        if (!(cOk && dOk) || strobeQ.size() != 2) begin
            nFail++;
            $display("FAIL bcast_complete: cmd=%0d done=%0d strobes=%0d expected 1 1 2", cOk, dOk, strobeQ.size());
        end
        for (int i = 0; i < strobeQ.size(); i++) begin
            nTests++;
            if (strobeQ[i].sel !== 8'hFF || strobeQ[i].wren !== 1'b1) begin
                nFail++;
                $display("FAIL bcast_sel%0d: got sel=%h wren=%b expected FF 1", i, strobeQ[i].sel, strobeQ[i].wren);
            end
        end
        clear_mon();
        read_burst(4'd0, 11'd0, 2, 1'b0, cOk, dOk);
        got0 = popQ;
        clear_mon();
        read_burst(4'd7, 11'd0, 2, 1'b0, cOk, dOk);
        nTests++;
        if (got0.size() != 2 || popQ.size() != 2) begin
            nFail++;
            $display("FAIL bcast_readback_len: t0=%0d t7=%0d expected 2 2", got0.size(), popQ.size());
        end else begin
            nTests++;
            if (got0[0] !== 32'h5A00 || got0[1] !== 32'h5A01 || popQ[0] !== 32'h5A00 || popQ[1] !== 32'h5A01) begin
                nFail++;
                $display("FAIL bcast_readback: t0=%h,%h t7=%h,%h expected 5a00,5a01", got0[0], got0[1], popQ[0], popQ[1]);
            end
        end
    endtask

    task automatic test_read_wrap();
        bit cOk, dOk;
        logic [AW-1:0] expAddr [4] = '{11'd2046, 11'd2047, 11'd0, 11'd1};
        clear_mon();
        write_burst(4'd5, 1'b0, 11'd2046, 4, 32'hC0DE0000, cOk, dOk);
        nTests++;
        if (strobeQ.size() != 4 || strobeQ[2].addr !== 11'd0 || strobeQ[3].addr !== 11'd1) begin
            nFail++;
            $display("FAIL wrap_write: strobes=%0d expected 4 with addr 2046,2047,0,1", strobeQ.size());
        end
        clear_mon();
        read_burst(4'd5, 11'd2046, 4, 1'b1, cOk, dOk);
        nTests++;
        if (strobeQ.size() != 4) begin
            nFail++;
            $display("FAIL wrap_read_count: got %0d expected 4", strobeQ.size());
        end
        for (int i = 0; i < 4 && i < strobeQ.size(); i++) begin
            nTests++;
            if (strobeQ[i].sel !== 8'h20 || strobeQ[i].wren !== 1'b0 || strobeQ[i].addr !== expAddr[i]) begin
                nFail++;
                $display("FAIL wrap_read_issue%0d: got sel=%h wren=%b addr=%0d expected 20 0 %0d",
                         i, strobeQ[i].sel, strobeQ[i].wren, strobeQ[i].addr, expAddr[i]);
            end
        end
        nTests++;
        if (popQ.size() != 4) begin
            nFail++;
            $display("FAIL wrap_pop_count: got %0d expected 4", popQ.size());
        end
        for (int i = 0; i < 4 && i < popQ.size(); i++) begin
            nTests++;
            if (popQ[i] !== 32'hC0DE0000 + 32'(i)) begin
                nFail++;
                $display("FAIL wrap_data%0d: got %h expected %h", i, popQ[i], 32'hC0DE0000 + 32'(i));
            end
        end
        nTests++;
        if (maxOutstanding > 2) begin
            nFail++;
            $display("FAIL wrap_outstanding: got %0d expected <= 2", maxOutstanding);
        end
        nTests++;
        if (!dOk || doneCount != 1 || errCount != 0 || doneCyc <= lastPopCyc) begin
            nFail++;
            $display("FAIL wrap_done: done=%0d err=%0d doneCyc=%0d lastPop=%0d expected 1 0 after last pop",
                     doneCount, errCount, doneCyc, lastPopCyc);
        end
    endtask

    task automatic test_len0_badthread();
        bit cOk;
        clear_mon();
        send_cmd(1'b0, 1'b0, 4'd3, 11'd20, 12'd0, cOk);
        nTests++;
        if (!cOk || oDONE !== 1'b1 || oERR !== 1'b0 || oCMD_READY !== 1'b0) begin
            nFail++;
            $display("FAIL len0_pulse: cmd=%0d done=%b err=%b ready=%b expected 1 1 0 0", cOk, oDONE, oERR, oCMD_READY);
        end
        repeat (3) @(posedge iACLK);
        #1;
        nTests++;
        if (doneCount != 1 || errCount != 0 || strobeQ.size() != 0 || oBUSY !== 1'b0) begin
            nFail++;
            $display("FAIL len0_status: done=%0d err=%0d strobes=%0d busy=%b expected 1 0 0 0", doneCount, errCount, strobeQ.size(), oBUSY);
        end
        clear_mon();
        iWR_VALID = 1'b1;
        iWR_DATA  = 32'hDEAD;
        send_cmd(1'b0, 1'b0, 4'd9, 11'd0, 12'd3, cOk);
        repeat (4) @(posedge iACLK);
        #1;
        iWR_VALID = 1'b0;
        nTests++;
        if (!cOk || doneCount != 1 || errCount != 1) begin
            nFail++;
            $display("FAIL badthread_pulse: cmd=%0d done=%0d err=%0d expected 1 1 1", cOk, doneCount, errCount);
        end
        nTests++;
        if (strobeQ.size() != 0 || wrBeats != 0 || oBUSY !== 1'b0) begin
            nFail++;
            $display("FAIL badthread_noaccess: strobes=%0d beats=%0d busy=%b expected 0 0 0", strobeQ.size(), wrBeats, oBUSY);
        end
    endtask

    task automatic test_reset_mid_read();
        bit cOk, dOk;
        clear_mon();
        write_burst(4'd2, 1'b0, 11'd100, 6, 32'hB0, cOk, dOk);
        clear_mon();
        iRD_READY = 1'b0;
        send_cmd(1'b1, 1'b0, 4'd2, 11'd100, 12'd6, cOk);
        repeat (6) @(posedge iACLK);
        #1;
        nTests++;
        if (!cOk || oRD_VALID !== 1'b1 || oBUSY !== 1'b1 || strobeQ.size() != 2) begin
            nFail++;
            $display("FAIL midread_full: cmd=%0d valid=%b busy=%b issued=%0d expected 1 1 1 2", cOk, oRD_VALID, oBUSY, strobeQ.size());
        end
        iARST = 1'b1;
        @(posedge iACLK); #1;
        iARST = 1'b0;
        nTests++;
        if (oRD_VALID !== 1'b0 || oLMEMSEL !== '0 || oBUSY !== 1'b0 || oDONE !== 1'b0) begin
            nFail++;
            $display("FAIL midread_abort: valid=%b sel=%h busy=%b done=%b expected 0 00 0 0", oRD_VALID, oLMEMSEL, oBUSY, oDONE);
        end
        clear_mon();
        repeat (4) @(posedge iACLK);
        #1;
        nTests++;
        if (doneCount != 0 || strobeQ.size() != 0) begin
            nFail++;
            $display("FAIL midread_quiet: done=%0d strobes=%0d expected 0 0", doneCount, strobeQ.size());
        end
        write_burst(4'd1, 1'b0, 11'd5, 2, 32'h77, cOk, dOk);
        nTests++;
        if (!(cOk && dOk) || doneCount != 1 || strobeQ.size() != 2 ||
            (strobeQ.size() == 2 && (strobeQ[0] !== {8'h02, 1'b1, 11'd5, 32'h77} || strobeQ[1] !== {8'h02, 1'b1, 11'd6, 32'h78}))) begin
            nFail++;
            $display("FAIL postreset_write: cmd=%0d done=%0d strobes=%0d expected 1 1 2 at thread1 addr 5,6",
                     cOk, doneCount, strobeQ.size());
        end
    endtask

    initial begin
        iARST = 1'b1; iCMD_VALID = 1'b0; iCMD_DIR = 1'b0; iCMD_BCAST = 1'b0;
        iCMD_THREAD = '0; iCMD_ADDR = '0; iCMD_LEN = '0;
        iWR_VALID = 1'b0; iWR_DATA = '0; iRD_READY = 1'b0;
        test_reset();
        test_write();
        test_bcast();
        test_read_wrap();
        test_len0_badthread();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
